dma_desc_sched: RTL and testbench
=================================

# dma_desc_sched

Multi-descriptor scheduler for the DMA engine: on a `go` start it snapshots all enabled, non-zero-length descriptors, dispatches them one at a time to the DMA streamer in ascending index order, and reports per-descriptor completion, global done/error and abort status to the CSR block. It sits between the DMA CSR (descriptors, control, status) and the DMA streamer (`s_dma_str_in_t` / `s_dma_str_out_t`). It replaces the fixed two-descriptor FSM with a `NUM_DESC`-parametrised one that adds abort draining, error termination and zero-length skipping.

## Interface
- `NUM_DESC`, default `` `DMA_NUM_DESC `` (4 in this generation): number of descriptors. Legal range is 2..16.
- `clk`  in  1  clock; the block uses only this clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `dma_ctrl_i`  in  `s_dma_control_t`  `go` and `abort_req` are used; `max_burst` is ignored.
- `dma_desc_i`  in  `s_dma_desc_t [NUM_DESC]`  descriptors; only `enable` and `num_bytes` are read.
- `dma_error_i`  in  `s_dma_error_t`  error report from the AXI side; only `valid` is used.
- `dma_stream_o`  out  `s_dma_str_in_t`  dispatch request (`valid`, `idx`) to the streamer.
- `dma_stream_i`  in  `s_dma_str_out_t`  `done` is a 1-cycle pulse from the streamer when the current descriptor finishes or drains.
- `dma_status_o`  out  `s_dma_status_t`  `done`, `error`.
- `dma_desc_done_o`  out  `NUM_DESC`  bit i = descriptor i completed in the current run.
- `dma_st_o`  out  `dma_st_t`  current state, for debug/CSR.

## Operation
- States: IDLE, CFG, RUN, ABORT, DONE.
- **Start:** `go` is edge-detected against the registered `go_q`. Start = `go & ~go_q`, and it is honoured only in IDLE.
- **On start:**
  - Latch `pend = enable & (num_bytes != 0)` per descriptor.
  - Clear `done`, `error` and `dma_desc_done_o`.
  - If `pend == 0`, go to DONE; otherwise go to CFG.
- **CFG:** register `idx` = lowest set bit of `pend`, then go to RUN.
- **RUN:** `dma_stream_o.valid = 1` with the stable `idx`. When `done` arrives:
  - Clear `pend[idx]` and set `dma_desc_done_o[idx]`.
  - Go to CFG if `pend` still has bits set, otherwise go to DONE.
- **Abort (`abort_req = 1`):**
  - In CFG, go to DONE.
  - In RUN without `done` in the same cycle, go to ABORT.
  - In RUN with `done` in the same cycle, the completion is recorded first, then go to DONE.
- **ABORT:** `valid = 0`. Wait for the streamer's drain `done` pulse, then go to DONE. The aborted descriptor is not marked done. No timeout.
- **Error (`dma_error_i.valid = 1`) in CFG, RUN or ABORT:**
  - Set the sticky `error`.
  - From RUN without `done`, go to ABORT. From RUN with a simultaneous `done`, do not mark the descriptor and go to DONE.
  - From CFG, go to DONE.
  - `error_i` in IDLE or DONE is ignored.
- **DONE:** `dma_status_o.done = 1`. Go to IDLE when `go == 0`.
  - `done`, `error` and `dma_desc_done_o` hold their values through IDLE until the next start.
- **Snapshot rule:** changes to `dma_desc_i` after the start cycle have no effect on the current run. `idx` is taken from the latched `pend` only.
- **Reset, including mid-run:** state = IDLE, `pend = 0`, `go_q = 0`. All outputs go to 0: `valid`, `idx`, `done`, `error`, `dma_desc_done_o`, and `dma_st_o = DMA_ST_IDLE`.

## Timing
- All outputs are registered or decoded directly from state/registers. There are no combinational input-to-output paths.
- **Dispatch latency:** `go` rises and is sampled at edge 0. The state is CFG after edge 0 and RUN after edge 1, so `valid` is high in the cycle after edge 1.
- **Between descriptors:** a `done` sampled at edge n gives CFG after edge n, so `valid` is low for exactly 1 cycle, then RUN with the new `idx` after edge n+1.
- **Completion:** after the last `done` at edge n, the state is DONE and `status.done = 1` after edge n.
- **Handshake:** `valid` stays high and `idx` stays stable until `done` is sampled. The streamer must not pulse `done` while `valid = 0`, except the drain pulse in ABORT.
- **Zero descriptors pending:** `status.done = 1` after the start edge.
- **Re-triggering:** holding `go` high never re-triggers a run; a `go` low→high edge is required.

## Structure
- **Package additions in `dma_pkg`:**
  - `dma_st_t` widened to `logic [2:0]` with `DMA_ST_ABORT` appended.
  - `` `DMA_NUM_DESC `` default raised to 4.
  - `idx_desc_t` stays `$clog2(`DMA_NUM_DESC)` wide.
  - `desc_mask_t = logic [`DMA_NUM_DESC-1:0]`.
- **Sub-module `dma_prio_enc`:** parametrised lowest-set-bit encoder.
  - Input: `NUM`-bit mask.
  - Outputs: `idx` (`$clog2(NUM)` bits) and `any`.
  - Purely combinational, instantiated once.

## Test plan
- **All descriptors enabled:** `NUM_DESC=4`, all enabled, `num_bytes` = 16/32/64/128, `go` pulse, streamer `done` 5 cycles after each `valid` rise → idx sequence 0,1,2,3; `valid` low 1 cycle between descriptors; `desc_done = 4'b1111`; `done = 1`, `error = 0`.
- **Sparse and zero-length:** enables = `4'b1010`, descriptor 3 with `num_bytes = 0` → only idx 1 is dispatched; `desc_done = 4'b0010`. Separately, all disabled → `done = 1` one cycle after the start edge, `valid` never asserted.
- **Abort during RUN:** `abort_req` during RUN of idx 2, drain `done` 3 cycles later → state ABORT for 3 cycles, `valid = 0`, `desc_done = 4'b0011`, `done = 1`, `error = 0`. Repeat with `abort_req` coincident with `done` → `desc_done = 4'b0111`, no ABORT state.
- **Error during RUN:** `error_i.valid` during RUN of idx 0 → ABORT; after drain, DONE with `error = 1`, `desc_done = 4'b0000`. A second `go` edge clears `error` and runs all descriptors cleanly.
- **Reset and retrigger:** `rst` asserted mid-RUN → all outputs 0 asynchronously, state IDLE. With `go` held high across DONE, no second run occurs until `go` toggles low→high.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared DMA types: control/status structs, descriptor layout, streamer
// handshake structs and the scheduler state encoding.
`ifndef DMA_NUM_DESC
`define DMA_NUM_DESC 4
`endif

package dma_pkg;

  localparam int DMA_NUM_DESC = `DMA_NUM_DESC;
  localparam int DMA_IDX_W    = $clog2(`DMA_NUM_DESC);

  typedef logic [DMA_IDX_W-1:0]     idx_desc_t;
  typedef logic [`DMA_NUM_DESC-1:0] desc_mask_t;

  // ABORT is appended last so the original encodings stay unchanged.
  typedef enum logic [2:0] {
    DMA_ST_IDLE  = 3'd0,
    DMA_ST_CFG   = 3'd1,
    DMA_ST_RUN   = 3'd2,
    DMA_ST_DONE  = 3'd3,
    DMA_ST_ABORT = 3'd4
  } dma_st_t;

  typedef struct packed {
    logic       go;
    logic       abort_req;
    logic [1:0] max_burst;
  } s_dma_control_t;

  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [31:0] num_bytes;
    logic        wr_mode;
    logic        rd_mode;
    logic        enable;
  } s_dma_desc_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        type_err;
    logic        src;
    logic        valid;
  } s_dma_error_t;

  typedef struct packed {
    logic      valid;
    idx_desc_t idx;
  } s_dma_str_in_t;

  typedef struct packed {
    logic done;
  } s_dma_str_out_t;

  typedef struct packed {
    logic done;
    logic error;
  } s_dma_status_t;

  // A descriptor takes part in a run only if enabled and it moves data.
  function automatic logic desc_is_pending(input s_dma_desc_t d);
    return d.enable & (d.num_bytes != 32'd0);
  endfunction

endpackage

// File: rtl/dma_prio_enc.sv
// Lowest-set-bit encoder: returns the index of the lowest set bit of
// mask_i and whether any bit is set at all. Purely combinational.
module dma_prio_enc #(
  parameter  int NUM = 4,
  localparam int IW  = $clog2(NUM)
) (
  input  logic [NUM-1:0] mask_i,
  output logic [IW-1:0]  idx_o,
  output logic           any_o
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx_o = '0;
    any_o = |mask_i;
    for (int i = NUM - 1; i >= 0; i--) begin
      idx_o = mask_i[i] ? IW'(i) : idx_o;
    end
  end

endmodule

// File: rtl/dma_desc_sched.sv
// Multi-descriptor DMA scheduler: snapshots the pending descriptor set on a
// go edge and dispatches descriptors one at a time, lowest index first,
// with abort draining, sticky error termination and zero-length skipping.
module dma_desc_sched
  import dma_pkg::*;
#(
  parameter int NUM_DESC = `DMA_NUM_DESC
) (
  input  logic                clk,
  input  logic                rst,
  input  s_dma_control_t      dma_ctrl_i,
  input  s_dma_desc_t         dma_desc_i [NUM_DESC],
  input  s_dma_error_t        dma_error_i,
  output s_dma_str_in_t       dma_stream_o,
  input  s_dma_str_out_t      dma_stream_i,
  output s_dma_status_t       dma_status_o,
  output logic [NUM_DESC-1:0] dma_desc_done_o,
  output dma_st_t             dma_st_o
);

  localparam int IW = $clog2(NUM_DESC);

  dma_st_t             state_q, state_d;
  logic [NUM_DESC-1:0] pend_q, pend_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                go_q, go_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [NUM_DESC-1:0] desc_done_q, desc_done_d;

  logic [NUM_DESC-1:0] new_pend_s;
  logic [IW-1:0]       enc_idx_s;
  logic                enc_any_s;
  logic                start_s;
  logic                str_done_s;
  logic                abort_s;
  logic                err_s;

  // Fields of the CSR/AXI structs that this block deliberately ignores.
  logic [NUM_DESC-1:0] unused_desc_s;
  logic                unused_misc_s;

  assign start_s    = dma_ctrl_i.go & ~go_q;
  assign str_done_s = dma_stream_i.done;
  assign abort_s    = dma_ctrl_i.abort_req;
  assign err_s      = dma_error_i.valid;
  assign go_d       = dma_ctrl_i.go;

  // Candidate pending set, latched only on the start cycle.
  always_comb begin
    new_pend_s    = '0;
    unused_desc_s = '0;
    for (int i = 0; i < NUM_DESC; i++) begin
      new_pend_s[i]    = desc_is_pending(dma_desc_i[i]);
      unused_desc_s[i] = ^dma_desc_i[i];
    end
  end

  assign unused_misc_s = ^{dma_ctrl_i.max_burst, dma_error_i.addr,
                           dma_error_i.type_err, dma_error_i.src};

  dma_prio_enc #(
    .NUM (NUM_DESC)
  ) u_prio_enc (
    .mask_i (pend_q),
    .idx_o  (enc_idx_s),
    .any_o  (enc_any_s)
  );

  // Next-state and bookkeeping for the dispatch FSM.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    idx_d       = idx_q;
    done_d      = done_q;
    error_d     = error_q;
    desc_done_d = desc_done_q;

    case (state_q)
      DMA_ST_IDLE: begin
        if (start_s) begin
          pend_d      = new_pend_s;
          done_d      = 1'b0;
          error_d     = 1'b0;
          desc_done_d = '0;
          state_d     = (|new_pend_s) ? DMA_ST_CFG : DMA_ST_DONE;
        end else begin
          state_d = DMA_ST_IDLE;
        end
      end

      DMA_ST_CFG: begin
        if (err_s) begin
          error_d = 1'b1;
          state_d = DMA_ST_DONE;
        end else if (abort_s) begin
          state_d = DMA_ST_DONE;
        end else if (enc_any_s) begin
          idx_d   = enc_idx_s;
          state_d = DMA_ST_RUN;
        end else begin
          state_d = DMA_ST_DONE;
        end
      end

      DMA_ST_RUN: begin
        if (err_s) begin
          // A completion racing an error is not credited to the descriptor.
          error_d = 1'b1;
          state_d = str_done_s ? DMA_ST_DONE : DMA_ST_ABORT;
        end else if (str_done_s) begin
          pend_d[idx_q]      = 1'b0;
          desc_done_d[idx_q] = 1'b1;
          if (abort_s) begin
            state_d = DMA_ST_DONE;
          end else if (pend_d != '0) begin
            state_d = DMA_ST_CFG;
          end else begin
            state_d = DMA_ST_DONE;
          end
        end else if (abort_s) begin
          state_d = DMA_ST_ABORT;
        end else begin
          state_d = DMA_ST_RUN;
        end
      end

      DMA_ST_ABORT: begin
        error_d = error_q | err_s;
        state_d = str_done_s ? DMA_ST_DONE : DMA_ST_ABORT;
      end

      DMA_ST_DONE: begin
        state_d = dma_ctrl_i.go ? DMA_ST_DONE : DMA_ST_IDLE;
      end

      default: begin
        state_d = DMA_ST_IDLE;
        pend_d  = '0;
      end
    endcase

    // Every path into DONE raises the global completion flag.
    done_d = done_d | (state_d == DMA_ST_DONE);
  end

  // State and status registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DMA_ST_IDLE;
      pend_q      <= '0;
      idx_q       <= '0;
      go_q        <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      desc_done_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      idx_q       <= idx_d;
      go_q        <= go_d;
      done_q      <= done_d;
      error_q     <= error_d;
      desc_done_q <= desc_done_d;
    end
  end

  // Outputs are decoded from registers only.
  always_comb begin
    dma_stream_o.valid = (state_q == DMA_ST_RUN);
    dma_stream_o.idx   = idx_desc_t'(idx_q);
    dma_status_o.done  = done_q;
    dma_status_o.error = error_q;
    dma_desc_done_o    = desc_done_q;
    dma_st_o           = state_q;
  end

endmodule

// File: tb/tb_dma_desc_sched.sv
// Self-checking bench for dma_desc_sched: table-driven clean runs with a
// streamer model, plus directed abort, error, reset and retrigger sequences.
module tb_dma_desc_sched;
  import dma_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  s_dma_control_t ctrl;
  s_dma_desc_t    desc [4];
  s_dma_error_t   err;
  s_dma_str_in_t  str_o;
  s_dma_str_out_t str_i;
  s_dma_status_t  status;
  logic [3:0]     desc_done;
  dma_st_t        st;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dma_desc_sched #(.NUM_DESC(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .dma_ctrl_i      (ctrl),
    .dma_desc_i      (desc),
    .dma_error_i     (err),
    .dma_stream_o    (str_o),
    .dma_stream_i    (str_i),
    .dma_status_o    (status),
    .dma_desc_done_o (desc_done),
    .dma_st_o        (st)
  );

  typedef struct {
    logic [3:0]  en;
    logic [3:0]  zero;
    int          lat;
    int          exp_n;
    logic [15:0] exp_seq;
    logic [3:0]  exp_dd;
    int          exp_cycles;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_desc(input logic [3:0] en, input logic [3:0] zero);
    for (int i = 0; i < 4; i++) begin
      desc[i].src_addr  = 32'h1000_0000 + 32'(i * 256);
      desc[i].dst_addr  = 32'h2000_0000 + 32'(i * 256);
      desc[i].num_bytes = zero[i] ? 32'd0 : (32'd16 << i);
      desc[i].wr_mode   = 1'b0;
      desc[i].rd_mode   = 1'b0;
      desc[i].enable    = en[i];
    end
  endtask

  // Go pulse, then a streamer that answers each dispatch lat cycles after valid rises.
  task automatic run_stream(input int lat, output int n, output logic [15:0] seq,
                            output int cycles, output int min_gap, output int max_gap);
    int   cnt;
    int   gap;
    logic prev_v;
    n = 0; seq = 16'h0; cycles = 0; min_gap = 1000; max_gap = 0;
    cnt = 0; gap = 0; prev_v = 1'b0;
    @(negedge clk); ctrl.go = 1'b1;
    @(negedge clk); ctrl.go = 1'b0; cycles = 1;
    while (cycles < 200) begin
      str_i.done = 1'b0;
      if (status.done) break;
      if (str_o.valid) begin
        if (!prev_v) begin
          n++;
          seq = {seq[11:0], 2'b00, str_o.idx};
          if (n > 1) begin
            min_gap = (gap < min_gap) ? gap : min_gap;
            max_gap = (gap > max_gap) ? gap : max_gap;
          end
          cnt = 0;
        end
        cnt++;
        if (cnt == lat) str_i.done = 1'b1;
      end else if (n > 0) begin
        gap = prev_v ? 1 : gap + 1;
      end
      prev_v = str_o.valid;
      @(negedge clk); cycles++;
    end
    if (!status.done) begin
      checks++; errors++;
      $display("FAIL run_timeout: got done=0 after %0d cycles expected done=1", cycles);
    end
    str_i.done = 1'b0;
  endtask

  task automatic start_run();
    @(negedge clk); ctrl.go = 1'b1;
    @(negedge clk); ctrl.go = 1'b0;
  endtask

  task automatic wait_valid(input logic [1:0] exp_idx, input string name);
    int t = 0;
    while (!str_o.valid && t < 50) begin
      @(negedge clk); t++;
    end
    if (!str_o.valid) begin
      checks++; errors++;
      $display("FAIL %s: got valid=0 after %0d cycles expected valid=1", name, t);
    end else begin
      check(name, 32'(str_o.idx), 32'(exp_idx));
    end
  endtask

  task automatic complete_cur();
    str_i.done = 1'b1;
    @(negedge clk);
    str_i.done = 1'b0;
  endtask

  task automatic run_all_clean(input string tag);
    for (int k = 0; k < 4; k++) begin
      wait_valid(2'(k), {tag, "_idx"});
      complete_cur();
    end
  endtask

  initial begin
    int          n, cyc, gmin, gmax;
    logic [15:0] seq;
    bit          vseen;

    //            en       zero     lat n  seq       dd       cycles
    vecs[0] = '{4'b1111, 4'b0000, 5,  4, 16'h0123, 4'b1111, 25};
    vecs[1] = '{4'b1010, 4'b1000, 3,  1, 16'h0001, 4'b0010, 5};
    vecs[2] = '{4'b0000, 4'b0000, 3,  0, 16'h0000, 4'b0000, 1};
    vecs[3] = '{4'b0110, 4'b0000, 1,  2, 16'h0012, 4'b0110, 5};
    vecs[4] = '{4'b1111, 4'b0101, 2,  2, 16'h0013, 4'b1010, 7};

    rst   = 1'b1;
    ctrl  = '0;
    err   = '0;
    str_i = '0;
    set_desc(4'b0000, 4'b0000);
    repeat (3) @(negedge clk);
    check("rst_state", 32'(st), 32'(DMA_ST_IDLE));
    check("rst_valid", 32'(str_o.valid), 32'd0);
    check("rst_status", 32'({status.done, status.error}), 32'd0);
    check("rst_desc_done", 32'(desc_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Clean runs from the vector table.
    for (int v = 0; v < 5; v++) begin
      set_desc(vecs[v].en, vecs[v].zero);
      run_stream(vecs[v].lat, n, seq, cyc, gmin, gmax);
      check($sformatf("v%0d_ndisp", v), 32'(n), 32'(vecs[v].exp_n));
      check($sformatf("v%0d_idx_seq", v), 32'(seq), 32'(vecs[v].exp_seq));
      check($sformatf("v%0d_desc_done", v), 32'(desc_done), 32'(vecs[v].exp_dd));
      check($sformatf("v%0d_done", v), 32'(status.done), 32'd1);
      check($sformatf("v%0d_error", v), 32'(status.error), 32'd0);
      check($sformatf("v%0d_cycles", v), 32'(cyc), 32'(vecs[v].exp_cycles));
      if (vecs[v].exp_n >= 2) begin
        check($sformatf("v%0d_gap_min", v), 32'(gmin), 32'd1);
        check($sformatf("v%0d_gap_max", v), 32'(gmax), 32'd1);
      end
      @(negedge clk);
      check($sformatf("v%0d_back_idle", v), 32'(st), 32'(DMA_ST_IDLE));
      check($sformatf("v%0d_hold_dd", v), 32'(desc_done), 32'(vecs[v].exp_dd));
    end

    // Abort during RUN of idx 2, drain 3 cycles later.
    set_desc(4'b1111, 4'b0000);
    start_run();
    wait_valid(2'd0, "abt_idx0"); complete_cur();
    wait_valid(2'd1, "abt_idx1"); complete_cur();
    wait_valid(2'd2, "abt_idx2");
    ctrl.abort_req = 1'b1;
    @(negedge clk); ctrl.abort_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("abt_state_c%0d", c), 32'(st), 32'(DMA_ST_ABORT));
      check($sformatf("abt_valid_c%0d", c), 32'(str_o.valid), 32'd0);
      if (c < 2) @(negedge clk);
    end
    complete_cur();
    check("abt_state_done", 32'(st), 32'(DMA_ST_DONE));
    check("abt_desc_done", 32'(desc_done), 32'b0011);
    check("abt_status", 32'({status.done, status.error}), 32'b10);

    // Abort coincident with done on idx 2: completion counts, no ABORT state.
    start_run();
    check("abtc_cleared_dd", 32'(desc_done), 32'd0);
    check("abtc_cleared_done", 32'(status.done), 32'd0);
    wait_valid(2'd0, "abtc_idx0"); complete_cur();
    wait_valid(2'd1, "abtc_idx1"); complete_cur();
    wait_valid(2'd2, "abtc_idx2");
    ctrl.abort_req = 1'b1;
    complete_cur();
    ctrl.abort_req = 1'b0;
    check("abtc_state", 32'(st), 32'(DMA_ST_DONE));
    check("abtc_desc_done", 32'(desc_done), 32'b0111);
    check("abtc_status", 32'({status.done, status.error}), 32'b10);

    // Error during RUN of idx 0, drain, then a clean rerun clears error.
    start_run();
    wait_valid(2'd0, "err_idx0");
    err.valid = 1'b1;
    @(negedge clk); err.valid = 1'b0;
    check("err_state", 32'(st), 32'(DMA_ST_ABORT));
    check("err_valid", 32'(str_o.valid), 32'd0);
    check("err_sticky", 32'({status.done, status.error}), 32'b01);
    complete_cur();
    check("err_state_done", 32'(st), 32'(DMA_ST_DONE));
    check("err_status", 32'({status.done, status.error}), 32'b11);
    check("err_desc_done", 32'(desc_done), 32'b0000);
    start_run();
    check("err_cleared", 32'(status.error), 32'd0);
    run_all_clean("rerun");
    check("rerun_status", 32'({status.done, status.error}), 32'b10);
    check("rerun_desc_done", 32'(desc_done), 32'b1111);

    // Asynchronous reset in the middle of RUN.
    start_run();
    wait_valid(2'd0, "rstm_idx0"); complete_cur();
    wait_valid(2'd1, "rstm_idx1");
    #2 rst = 1'b1;
    #1;
    check("rstm_state", 32'(st), 32'(DMA_ST_IDLE));
    check("rstm_stream", 32'({str_o.valid, str_o.idx}), 32'd0);
    check("rstm_status", 32'({status.done, status.error}), 32'd0);
    check("rstm_desc_done", 32'(desc_done), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("rstm_stays_idle", 32'(st), 32'(DMA_ST_IDLE));

    // go held high across DONE; descriptors changed after start are ignored.
    @(negedge clk); ctrl.go = 1'b1;
    @(negedge clk);
    set_desc(4'b0000, 4'b0000);
    run_all_clean("hold");
    check("hold_snapshot_dd", 32'(desc_done), 32'b1111);
    vseen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      vseen = vseen | str_o.valid;
    end
    check("hold_no_retrig_valid", 32'(vseen), 32'd0);
    check("hold_state_done", 32'(st), 32'(DMA_ST_DONE));
    ctrl.go = 1'b0;
    @(negedge clk);
    check("hold_to_idle", 32'(st), 32'(DMA_ST_IDLE));
    check("hold_idle_dd", 32'(desc_done), 32'b1111);
    set_desc(4'b1111, 4'b0000);
    ctrl.go = 1'b1;
    @(negedge clk);
    ctrl.go = 1'b0;
    check("retrig_state", 32'(st), 32'(DMA_ST_CFG));
    check("retrig_cleared", 32'({status.done, desc_done}), 32'd0);
    run_all_clean("retrig");
    check("retrig_status", 32'({status.done, status.error}), 32'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
